spart_driver: RTL and testbench

SPART_DRIVER -- requirements
Module: spart_driver

---
 rtl/spart_driver.sv | 203 ++++++++++++++++++++
 tb/tb_spart_driver.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_driver.sv
// spart_driver: bus master that programs the SPART baud divisor and then
// echoes every received byte back out through the transmit buffer.
// A change of the baud switches re-runs the divisor programming sequence.
module spart_driver #(
    parameter logic [15:0] DIV_4800  = 16'd650,
    parameter logic [15:0] DIV_9600  = 16'd325,
    parameter logic [15:0] DIV_19200 = 16'd162,
    parameter logic [15:0] DIV_38400 = 16'd80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    localparam logic [2:0] INIT_LO  = 3'd0;
    localparam logic [2:0] INIT_HI  = 3'd1;
    localparam logic [2:0] WAIT_RDA = 3'd2;
    localparam logic [2:0] READ_RX  = 3'd3;
    localparam logic [2:0] WAIT_TBR = 3'd4;
    localparam logic [2:0] WRITE_TX = 3'd5;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    // Baud switch setting to divisor value.
    function automatic logic [15:0] div_sel(input logic [1:0] cfg);
        logic [15:0] d;
        case (cfg)
            2'b00:   d = DIV_4800;
            2'b01:   d = DIV_9600;
            2'b10:   d = DIV_19200;
            2'b11:   d = DIV_38400;
            default: d = DIV_9600;
        endcase
        return d;
    endfunction

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    // Low for the first cycle after reset so the bus stays idle until the
    // first real INIT_LO cycle is presented.
    logic        run_r;
    logic [1:0]  br_cfg_q_r;
    logic        reinit_pend_r;
    logic        cfg_chg_s;
    logic [15:0] divisor_s;
    logic [7:0]  rx_byte_r;
    logic        rx_valid_r;
    logic        drive_r;
    logic [7:0]  dout_s;
    logic        cs_nxt_s;
    logic        rw_nxt_s;
    logic [1:0]  addr_nxt_s;

    assign cfg_chg_s = (br_cfg != br_cfg_q_r);
    assign divisor_s = div_sel(br_cfg_q_r);

    // Next-state selection; a pending reinit pre-empts both wait states.
    always_comb begin
        state_nxt_s = state_r;
        if (!run_r) begin
            state_nxt_s = INIT_LO;
        end else begin
            case (state_r)
                INIT_LO:  state_nxt_s = INIT_HI;
                INIT_HI:  state_nxt_s = WAIT_RDA;
                WAIT_RDA: begin
                    if (reinit_pend_r) begin
                        state_nxt_s = INIT_LO;
                    end else if (rda) begin
                        state_nxt_s = READ_RX;
                    end else begin
                        state_nxt_s = WAIT_RDA;
                    end
                end
                READ_RX:  state_nxt_s = WAIT_TBR;
                WAIT_TBR: begin
                    if (reinit_pend_r) begin
                        state_nxt_s = INIT_LO;
                    end else if (tbr) begin
                        state_nxt_s = WRITE_TX;
                    end else begin
                        state_nxt_s = WAIT_TBR;
                    end
                end
                WRITE_TX: state_nxt_s = WAIT_RDA;
                default:  state_nxt_s = INIT_LO;
            endcase
        end
    end

    // Bus control values for the state being entered (registered below).
    // Each access state lasts one cycle; only the divisor pair is back to back.
    always_comb begin
        cs_nxt_s   = 1'b0;
        rw_nxt_s   = 1'b1;
        addr_nxt_s = ADDR_BUF;
        case (state_nxt_s)
            INIT_LO: begin
                cs_nxt_s   = 1'b1;
                rw_nxt_s   = 1'b0;
                addr_nxt_s = ADDR_DIV_LO;
            end
            INIT_HI: begin
                cs_nxt_s   = 1'b1;
                rw_nxt_s   = 1'b0;
                addr_nxt_s = ADDR_DIV_HI;
            end
            READ_RX: begin
                cs_nxt_s   = 1'b1;
                rw_nxt_s   = 1'b1;
                addr_nxt_s = ADDR_BUF;
            end
            WRITE_TX: begin
                cs_nxt_s   = 1'b1;
                rw_nxt_s   = 1'b0;
                addr_nxt_s = ADDR_BUF;
            end
            default: begin
                cs_nxt_s   = 1'b0;
                rw_nxt_s   = 1'b1;
                addr_nxt_s = ADDR_BUF;
            end
        endcase
    end

    // Write data for the access currently presented on the bus.
    always_comb begin
        dout_s = 8'h00;
        case (state_r)
            INIT_LO:  dout_s = divisor_s[7:0];
            INIT_HI:  dout_s = divisor_s[15:8];
            WRITE_TX: dout_s = rx_byte_r;
            default:  dout_s = 8'h00;
        endcase
    end

    assign databus  = drive_r ? dout_s : 8'bzzzz_zzzz;
    assign rx_byte  = rx_byte_r;
    assign rx_valid = rx_valid_r;

    // State, registered bus controls and run gate.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= INIT_LO;
            run_r   <= 1'b0;
            iocs    <= 1'b0;
            iorw    <= 1'b1;
            ioaddr  <= ADDR_BUF;
            drive_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            run_r   <= 1'b1;
            iocs    <= cs_nxt_s;
            iorw    <= rw_nxt_s;
            ioaddr  <= addr_nxt_s;
            drive_r <= cs_nxt_s & ~rw_nxt_s;
        end
    end

    // Baud switch sampling and reinit request; a fresh change beats the clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            br_cfg_q_r    <= br_cfg;
            reinit_pend_r <= 1'b0;
        end else begin
            br_cfg_q_r <= br_cfg;
            if (cfg_chg_s) begin
                reinit_pend_r <= 1'b1;
            end else if (state_nxt_s == INIT_LO) begin
                reinit_pend_r <= 1'b0;
            end else begin
                reinit_pend_r <= reinit_pend_r;
            end
        end
    end

    // Capture the received byte at the end of the read strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_byte_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            if (run_r && (state_r == READ_RX)) begin
                rx_byte_r  <= databus;
                rx_valid_r <= 1'b1;
            end else begin
                rx_byte_r  <= rx_byte_r;
                rx_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a table of baud/echo vectors plus hand-written
// reinit and reset sequences; a negedge monitor pops expected bus accesses.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] rx_byte;
    logic       rx_valid;

    // SPART side of the bus: drives the RX byte on reads, a marker otherwise.
    logic [7:0] spart_rx;
    logic       tb_oe;
    logic [7:0] tb_val;
    assign tb_oe   = !((iocs === 1'b1) && (iorw === 1'b0));
    assign tb_val  = ((iocs === 1'b1) && (iorw === 1'b1)) ? spart_rx : 8'h3C;
    assign databus = tb_oe ? tb_val : 8'bzzzz_zzzz;

    always #5 clk = ~clk;

    spart_driver dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .rda      (rda),
        .tbr      (tbr),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid)
    );

    typedef struct {
        logic [1:0] addr;
        logic       rw;
        logic [7:0] data;
    } acc_t;

    typedef struct {
        logic [1:0] cfg;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] rx;
        int         tbr_wait;
    } vec_t;

    acc_t expq[$];
    vec_t vecs[4];
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_acc(input logic [1:0] a, input logic rw, input logic [7:0] d);
        acc_t e;
        e.addr = a;
        e.rw   = rw;
        e.data = d;
        expq.push_back(e);
    endtask

    // Bus monitor: scoreboard pops, idle checks, rx_valid model.
    initial begin
        logic       prev_cs;
        logic [1:0] prev_addr;
        logic       prev_rd;
        logic [7:0] prev_data;
        acc_t       e;
        prev_cs   = 1'b0;
        prev_addr = 2'b00;
        prev_rd   = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (iocs === 1'b1) begin
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_access: got addr=%0h rw=%0b data=%0h want none at %0t",
                                 ioaddr, iorw, databus, $time);
                    end else begin
                        e = expq.pop_front();
                        chk("acc_addr", {30'd0, ioaddr}, {30'd0, e.addr});
                        chk("acc_rw", {31'd0, iorw}, {31'd0, e.rw});
                        if (e.rw == 1'b0) begin
                            chk("acc_wdata", {24'd0, databus}, {24'd0, e.data});
                        end else begin
                            chk("acc_rbus", {24'd0, databus}, {24'd0, spart_rx});
                        end
                    end
                    if (prev_cs) begin
                        chk("cs_pair", {28'd0, prev_addr, ioaddr}, {28'd0, 2'b10, 2'b11});
                    end
                end else begin
                    chk("idle_iocs", {31'd0, iocs}, 32'd0);
                    chk("idle_iorw", {31'd0, iorw}, 32'd1);
                    chk("idle_addr", {30'd0, ioaddr}, 32'd0);
                    chk("idle_hiz", {24'd0, databus}, {24'd0, 8'h3C});
                end
                chk("rx_valid", {31'd0, rx_valid}, {31'd0, prev_rd});
                if (prev_rd) begin
                    chk("rx_byte", {24'd0, rx_byte}, {24'd0, prev_data});
                end
                prev_cs   = (iocs === 1'b1);
                prev_addr = ioaddr;
                prev_rd   = (iocs === 1'b1) && (iorw === 1'b1);
                prev_data = databus;
            end
        end
    end

    task automatic do_reset(input logic [1:0] cfg, input logic [7:0] lo, input logic [7:0] hi);
        rst    = 1'b0;
        rda    = 1'b0;
        tbr    = 1'b0;
        br_cfg = cfg;
        step();
        step();
        mon_en = 1'b1;
        chk("rst_iocs", {31'd0, iocs}, 32'd0);
        chk("rst_iorw", {31'd0, iorw}, 32'd1);
        chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        push_acc(2'b10, 1'b0, lo);
        push_acc(2'b11, 1'b0, hi);
        rst = 1'b1;
        step();
        chk("init_lo", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b10, lo});
        step();
        chk("init_hi", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b11, hi});
        step();
        chk("init_done", {31'd0, iocs}, 32'd0);
    endtask

    task automatic echo(input logic [7:0] b, input int wait_n);
        spart_rx = b;
        push_acc(2'b00, 1'b1, b);
        push_acc(2'b00, 1'b0, b);
        rda = 1'b1;
        step();
        chk("rd_strobe", {28'd0, iocs, iorw, ioaddr}, {28'd0, 1'b1, 1'b1, 2'b00});
        rda = 1'b0;
        tbr = 1'b0;
        step();
        for (int i = 0; i < wait_n; i++) begin
            chk("tbr_hold", {31'd0, iocs}, 32'd0);
            step();
        end
        tbr = 1'b1;
        step();
        chk("wr_strobe", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b00, b});
        tbr = 1'b0;
        step();
        chk("wr_done", {31'd0, iocs}, 32'd0);
        chk("rx_byte_echo", {24'd0, rx_byte}, {24'd0, b});
    endtask

    initial begin
        int budget;
        rst      = 1'b0;
        rda      = 1'b0;
        tbr      = 1'b0;
        br_cfg   = 2'b01;
        spart_rx = 8'h00;

        vecs[0] = '{2'b00, 8'h8A, 8'h02, 8'h41, 0};
        vecs[1] = '{2'b01, 8'h45, 8'h01, 8'h00, 3};
        vecs[2] = '{2'b10, 8'hA2, 8'h00, 8'hFF, 20};
        vecs[3] = '{2'b11, 8'h50, 8'h00, 8'h5A, 1};

        for (int i = 0; i < 4; i++) begin
            do_reset(vecs[i].cfg, vecs[i].lo, vecs[i].hi);
            echo(vecs[i].rx, vecs[i].tbr_wait);
            echo(~vecs[i].rx, 0);
        end

        // Baud change while an echo byte is pending: byte dropped, reinit at 38400.
        do_reset(2'b01, 8'h45, 8'h01);
        spart_rx = 8'h55;
        push_acc(2'b00, 1'b1, 8'h55);
        rda = 1'b1;
        step();
        rda = 1'b0;
        step();
        step();
        push_acc(2'b10, 1'b0, 8'h50);
        push_acc(2'b11, 1'b0, 8'h00);
        br_cfg = 2'b11;
        step();
        chk("reinit_wait", {31'd0, iocs}, 32'd0);
        step();
        chk("reinit_lo", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b10, 8'h50});
        step();
        chk("reinit_hi", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b11, 8'h00});
        step();
        tbr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("no_stale_echo", {31'd0, iocs}, 32'd0);
            step();
        end
        tbr = 1'b0;

        // Change during INIT_HI forces a second reinit.
        push_acc(2'b10, 1'b0, 8'hA2);
        push_acc(2'b11, 1'b0, 8'h00);
        push_acc(2'b10, 1'b0, 8'h8A);
        push_acc(2'b11, 1'b0, 8'h02);
        br_cfg = 2'b10;
        step();
        step();
        chk("re1_lo", {24'd0, databus}, {24'd0, 8'hA2});
        step();
        br_cfg = 2'b00;
        step();
        chk("re_gap", {31'd0, iocs}, 32'd0);
        step();
        chk("re2_lo", {28'd0, iocs, iorw, ioaddr}, {28'd0, 1'b1, 1'b0, 2'b10});
        step();
        step();

        // rda together with a pending reinit: reinit first, then the read.
        br_cfg = 2'b01;
        step();
        rda = 1'b1;
        spart_rx = 8'hC3;
        push_acc(2'b10, 1'b0, 8'h45);
        push_acc(2'b11, 1'b0, 8'h01);
        push_acc(2'b00, 1'b1, 8'hC3);
        push_acc(2'b00, 1'b0, 8'hC3);
        step();
        chk("reinit_wins", {28'd0, iocs, iorw, ioaddr}, {28'd0, 1'b1, 1'b0, 2'b10});
        step();
        step();
        step();
        chk("late_read", {28'd0, iocs, iorw, ioaddr}, {28'd0, 1'b1, 1'b1, 2'b00});
        rda = 1'b0;
        tbr = 1'b1;
        step();
        step();
        chk("late_write", {24'd0, databus}, {24'd0, 8'hC3});
        tbr = 1'b0;
        step();

        // Reset during WRITE_TX aborts the write.
        spart_rx = 8'h99;
        push_acc(2'b00, 1'b1, 8'h99);
        push_acc(2'b00, 1'b0, 8'h99);
        rda = 1'b1;
        step();
        rda = 1'b0;
        tbr = 1'b1;
        step();
        step();
        chk("abort_wr", {20'd0, iocs, iorw, ioaddr, databus}, {20'd0, 1'b1, 1'b0, 2'b00, 8'h99});
        rst = 1'b0;
        tbr = 1'b0;
        step();
        chk("abort_iocs", {31'd0, iocs}, 32'd0);
        chk("abort_hiz", {24'd0, databus}, {24'd0, 8'h3C});
        chk("abort_rx_byte", {24'd0, rx_byte}, 32'd0);
        do_reset(2'b10, 8'hA2, 8'h00);
        echo(8'h7E, 2);

        budget = 0;
        while ((expq.size() != 0) && (budget < 20)) begin
            step();
            budget++;
        end
        chk("queue_drained", expq.size(), 32'd0);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
